// File: rtl/rr_onehot_sel_arb.sv
// rr_onehot_sel_arb
// -----------------------------------------------------------------------------
// Round-robin arbiter that generates the one-hot select for an N:1 one-hot mux.
// The grant is registered, so the mux select is glitch-free and stable for the
// whole grant. A winner keeps its grant for as long as it holds its request.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined   -> an owner is forced to rotate after MAX_HOLD consecutive grant
//                cycles, but only if some other requester is waiting.
//   Undefined -> no hold counter exists; MAX_HOLD is only range-checked.
//
// Parameters
//   N         number of requesters / mux inputs (2..16)
//   MAX_HOLD  max consecutive grant cycles when ARB_TIMEOUT_EN is defined (>=1)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high reset
//   req_i        in   [N-1:0] request vector, one bit per requester
//   gnt_o        out  [N-1:0] registered one-hot grant, all-zero when idle
//   gnt_vld_o    out  1 when gnt_o is non-zero
//   gnt_idx_o    out  [$clog2(N)-1:0] binary index of the owner, 0 when idle
//   dbg_state_o  out  FSM state for checkers (0 = IDLE, 1 = GRANT)
//
// Handshake: there is no ready/acknowledge. A requester owns the mux from the
// cycle after gnt_o shows its bit until the cycle after it drops req_i; any
// single-cycle low on its req_i bit counts as a release.
// -----------------------------------------------------------------------------
module rr_onehot_sel_arb #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gnt_o,
    output logic                 gnt_vld_o,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 dbg_state_o
);

    localparam int IW = $clog2(N);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_bad_param
        $error("rr_onehot_sel_arb: N must be 2..16 and MAX_HOLD >= 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q,   gnt_d;
    logic [IW-1:0]   idx_q,   idx_d;
    logic [IW-1:0]   ptr_q,   ptr_d;

    // Circular priority search: first set bit of req at or after start.
    // Returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] req,
                                            input logic [IW-1:0] start);
        logic          found;
        logic [IW-1:0] win;
        int            j;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(start) + i;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = j[IW-1:0];
            end
        end
        return {found, win};
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    logic [IW-1:0] succ;       // (idx_q + 1) % N
    logic [IW:0]   pick_ptr;   // search used when leaving IDLE
    logic [IW:0]   pick_succ;  // search after the owner, owner masked out

    assign succ      = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);
    assign pick_ptr  = rr_pick(req_i, ptr_q);
    // Masking the owner makes it lowest priority for both a release (its bit
    // is already 0) and a forced timeout rotation (its bit is still 1).
    assign pick_succ = rr_pick(req_i & ~gnt_q, succ);

`ifdef ARB_TIMEOUT_EN
    logic [HW-1:0] hold_q, hold_d;
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_ptr[IW]) begin
                    state_d = GRANT;
                    idx_d   = pick_ptr[IW-1:0];
                    gnt_d   = onehot(pick_ptr[IW-1:0]);
`ifdef ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (!req_i[idx_q]) begin
                    // Release: pointer moves past the old owner whether or
                    // not someone else is waiting.
                    ptr_d = succ;
                    if (pick_succ[IW]) begin
                        idx_d = pick_succ[IW-1:0];
                        gnt_d = onehot(pick_succ[IW-1:0]);
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        gnt_d   = '0;
                    end
`ifdef ARB_TIMEOUT_EN
                    hold_d = '0;
`endif
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    // Hold budget used up: rotate if anyone else waits,
                    // otherwise the owner keeps it and the budget restarts.
                    if (pick_succ[IW]) begin
                        ptr_d = succ;
                        idx_d = pick_succ[IW-1:0];
                        gnt_d = onehot(pick_succ[IW-1:0]);
                    end
                    hold_d = '0;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_vld_o   = (state_q == GRANT);
    assign gnt_idx_o   = idx_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rr_onehot_sel_arb.sv
// Testbench for rr_onehot_sel_arb (N=4, MAX_HOLD=4). Directed scenarios with
// constant expectations, then randomized traffic against a reference model
// that tracks owner / pointer / hold count as plain integers.
module tb_rr_onehot_sel_arb;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req_i = '0;
    logic [N-1:0] gnt_o;
    logic         gnt_vld_o;
    logic [1:0]   gnt_idx_o;
    logic         dbg_state_o;

    int n_checks = 0;
    int n_pass   = 0;

    rr_onehot_sel_arb #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .gnt_vld_o   (gnt_vld_o),
        .gnt_idx_o   (gnt_idx_o),
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int owner;   // -1 when idle
        int ptr;
        int hold;
    } mstate_t;

    mstate_t m;

    function automatic int find_from(input logic [N-1:0] req, input int start,
                                     input int excl);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (j != excl && req[j]) return j;
        end
        return -1;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic [N-1:0] req);
        mstate_t n;
        int w;
        n = s;
        if (s.owner < 0) begin
            w = find_from(req, s.ptr, -1);
            if (w >= 0) begin
                n.owner = w;
                n.hold  = 0;
            end
        end else if (!req[s.owner]) begin
            n.ptr   = (s.owner + 1) % N;
            n.owner = find_from(req, n.ptr, -1);
            n.hold  = 0;
        end else begin
`ifdef ARB_TIMEOUT_EN
            if (s.hold == MAX_HOLD - 1) begin
                w = find_from(req, (s.owner + 1) % N, s.owner);
                if (w >= 0) begin
                    n.ptr   = (s.owner + 1) % N;
                    n.owner = w;
                end
                n.hold = 0;
            end else begin
                n.hold = s.hold + 1;
            end
`endif
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (reset) m <= '{owner: -1, ptr: 0, hold: 0};
        else       m <= model_next(m, req_i);
    end

    // ---------------- driver ----------------
    // Inputs change on the falling edge; outputs are sampled 1ns after the
    // following rising edge.
    task automatic drive(input logic rst, input logic [N-1:0] req);
        @(negedge clk);
        reset = rst;
        req_i = req;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'hF);
            n_checks++;
            if (gnt_o !== 4'b0 || gnt_vld_o !== 1'b0 || gnt_idx_o !== 2'd0)
                $display("FAIL reset_hold cyc%0d: gnt=%b vld=%b idx=%0d, want 0000/0/0",
                         i, gnt_o, gnt_vld_o, gnt_idx_o);
            else n_pass++;
        end
        drive(1'b0, 4'hF);
        n_checks++;
        if (gnt_o !== 4'b0001 || gnt_vld_o !== 1'b1 || gnt_idx_o !== 2'd0)
            $display("FAIL reset_release: gnt=%b vld=%b idx=%0d, want 0001/1/0",
                     gnt_o, gnt_vld_o, gnt_idx_o);
        else n_pass++;
    endtask

    task automatic test_single_hold();
        drive(1'b0, 4'b0000);
        n_checks++;
        if (gnt_o !== 4'b0 || gnt_vld_o !== 1'b0)
            $display("FAIL to_idle: gnt=%b vld=%b, want 0000/0", gnt_o, gnt_vld_o);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 4'b0100);
            n_checks++;
            if (gnt_o !== 4'b0100 || gnt_idx_o !== 2'd2 || gnt_vld_o !== 1'b1)
                $display("FAIL single_hold cyc%0d: gnt=%b idx=%0d vld=%b, want 0100/2/1",
                         i, gnt_o, gnt_idx_o, gnt_vld_o);
            else n_pass++;
        end
        drive(1'b0, 4'b0000);
        n_checks++;
        if (gnt_o !== 4'b0 || gnt_vld_o !== 1'b0 || gnt_idx_o !== 2'd0)
            $display("FAIL single_drop: gnt=%b vld=%b idx=%0d, want 0000/0/0",
                     gnt_o, gnt_vld_o, gnt_idx_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back_wrap();
        logic [N-1:0] reqs [3] = '{4'b1001, 4'b1000, 4'b0001};
        logic [N-1:0] exps [3] = '{4'b0001, 4'b1000, 4'b0001};
        drive(1'b1, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, reqs[i]);
            n_checks++;
            if (gnt_o !== exps[i] || gnt_vld_o !== 1'b1)
                $display("FAIL b2b_wrap step%0d: gnt=%b vld=%b, want %b/1",
                         i, gnt_o, gnt_vld_o, exps[i]);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        logic [N-1:0] exp;
        drive(1'b1, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 4'b0011);
`ifdef ARB_TIMEOUT_EN
            exp = ((c / MAX_HOLD) % 2 == 1) ? 4'b0010 : 4'b0001;
`else
            exp = 4'b0001;
`endif
            n_checks++;
            if (gnt_o !== exp)
                $display("FAIL timeout_pair cyc%0d: gnt=%b, want %b", c, gnt_o, exp);
            else n_pass++;
        end
        drive(1'b1, 4'b0000);
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 4'b0001);
            n_checks++;
            if (gnt_o !== 4'b0001)
                $display("FAIL timeout_alone cyc%0d: gnt=%b, want 0001", c, gnt_o);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b0010);
        drive(1'b0, 4'b0100);   // release of 1 moves the pointer to 2
        n_checks++;
        if (gnt_o !== 4'b0100)
            $display("FAIL mid_setup: gnt=%b, want 0100", gnt_o);
        else n_pass++;
        drive(1'b1, 4'b0110);
        n_checks++;
        if (gnt_o !== 4'b0 || gnt_vld_o !== 1'b0 || gnt_idx_o !== 2'd0)
            $display("FAIL mid_reset: gnt=%b vld=%b idx=%0d, want 0000/0/0",
                     gnt_o, gnt_vld_o, gnt_idx_o);
        else n_pass++;
        drive(1'b0, 4'b0110);
        n_checks++;
        if (gnt_o !== 4'b0010 || gnt_idx_o !== 2'd1)
            $display("FAIL mid_after: gnt=%b idx=%0d, want 0010/1", gnt_o, gnt_idx_o);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [N-1:0] req, exp_gnt;
        logic [1:0]   exp_idx;
        logic         rst;
        req = '0;
        drive(1'b1, 4'b0000);
        for (int c = 0; c < 400; c++) begin
            // Mostly keep requests steady so owners hold for a while.
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 59) == 0);
            drive(rst, req);
            exp_gnt = (m.owner < 0) ? 4'b0 : 4'(1 << m.owner);
            exp_idx = (m.owner < 0) ? 2'd0 : 2'(m.owner);
            n_checks++;
            if (gnt_o !== exp_gnt || gnt_idx_o !== exp_idx || gnt_vld_o !== (m.owner >= 0))
                $display("FAIL random cyc%0d req=%b: gnt=%b idx=%0d vld=%b, want %b/%0d/%b",
                         c, req, gnt_o, gnt_idx_o, gnt_vld_o, exp_gnt, exp_idx, m.owner >= 0);
            else n_pass++;
            n_checks++;
            if (gnt_o !== (gnt_vld_o ? 4'(1 << gnt_idx_o) : 4'b0) || $countones(gnt_o) > 1)
                $display("FAIL random_consistency cyc%0d: gnt=%b vld=%b idx=%0d",
                         c, gnt_o, gnt_vld_o, gnt_idx_o);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_back_to_back_wrap();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
